// File: rtl/piece_commit.sv
// piece_commit: collision-checks the active tetromino against the board RAM and,
// on request, writes its four cells before handing the board to row-clear.
module piece_commit #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       op,
  input  logic [2:0] shape,
  input  logic [1:0] rot,
  input  logic [4:0] piece_x,
  input  logic [5:0] piece_y,
  input  logic [5:0] colour,
  input  logic [5:0] ram_Q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       clr_enable,
  input  logic       clr_complete,
  output logic       busy,
  output logic       collide,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RD_SAMPLE = 3'd3,
    ST_WR        = 3'd4,
    ST_WR_END    = 3'd5,
    ST_CLEAR     = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_collide_nxt;

  logic       r_op;
  logic [2:0] r_shape;
  logic [1:0] r_rot;
  logic [4:0] r_px;
  logic [5:0] r_py;
  logic [5:0] r_colour;
  logic [1:0] r_idx;
  logic       r_collide;
  logic [7:0] r_ram_addr;
  logic [5:0] r_ram_data;
  logic       r_ram_wren;
  logic       r_clr_en;

  logic [3:0] w_cell;
  logic [5:0] w_cx;
  logic [6:0] w_cy;
  logic       w_oob;
  logic [7:0] w_addr;
  logic       w_last;

  // Rotation-0 cell {dx,dy} of a shape; cell 0 sits in the low nibble.
  function automatic logic [3:0] base_cell(input logic [2:0] shp, input logic [1:0] idx);
    logic [15:0] tbl;
    case (shp)
      3'd0:    tbl = {2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
      3'd1:    tbl = {2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
      3'd2:    tbl = {2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
      3'd3:    tbl = {2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
      3'd4:    tbl = {2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      3'd5:    tbl = {2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
      3'd6:    tbl = {2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
      default: tbl = {2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    endcase
    return tbl[{idx, 2'b00} +: 4];
  endfunction

  // Closed form of applying (dx,dy) -> (3-dy,dx) r times.
  function automatic logic [3:0] rotate_cell(input logic [3:0] c, input logic [1:0] r);
    logic [1:0] dx;
    logic [1:0] dy;
    logic [3:0] res;
    dx = c[3:2];
    dy = c[1:0];
    case (r)
      2'd0:    res = {dx, dy};
      2'd1:    res = {2'd3 - dy, dx};
      2'd2:    res = {2'd3 - dx, 2'd3 - dy};
      default: res = {dy, 2'd3 - dx};
    endcase
    return res;
  endfunction

  assign w_cell = rotate_cell(base_cell(r_shape, r_idx), r_rot);
  assign w_cx   = {1'b0, r_px} + {4'b0000, w_cell[3:2]};
  assign w_cy   = {1'b0, r_py} + {5'b00000, w_cell[1:0]};
  assign w_oob  = (w_cx >= 6'(BOARD_W)) || (w_cy >= 7'(BOARD_H));
  assign w_addr = 8'(w_cy) * 8'(BOARD_W) + 8'(w_cx);
  assign w_last = (r_idx == 2'd3);

  // Next-state logic; the check exit must see a collision found on the final cell.
  always_comb begin
    w_state_nxt   = r_state;
    w_collide_nxt = r_collide;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RD_ADDR;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RD_ADDR: begin
        if (w_oob) begin
          w_collide_nxt = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
          else        w_state_nxt = ST_RD_ADDR;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: w_state_nxt = ST_RD_SAMPLE;
      ST_RD_SAMPLE: begin
        if (ram_Q != 6'd0) w_collide_nxt = 1'b1;
        else               w_collide_nxt = r_collide;
        if (w_last) begin
          if (r_op && !w_collide_nxt) w_state_nxt = ST_WR;
          else                        w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RD_ADDR;
        end
      end
      ST_WR: w_state_nxt = ST_WR_END;
      ST_WR_END: begin
        if (w_last) w_state_nxt = ST_CLEAR;
        else        w_state_nxt = ST_WR;
      end
      ST_CLEAR: begin
        if (clr_complete) w_state_nxt = ST_DONE;
        else              w_state_nxt = ST_CLEAR;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request latch, cell walk and RAM port registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op       <= 1'b0;
      r_shape    <= 3'd0;
      r_rot      <= 2'd0;
      r_px       <= 5'd0;
      r_py       <= 6'd0;
      r_colour   <= 6'd0;
      r_idx      <= 2'd0;
      r_collide  <= 1'b0;
      r_ram_addr <= 8'd0;
      r_ram_data <= 6'd0;
      r_ram_wren <= 1'b0;
      r_clr_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_shape   <= shape;
            r_rot     <= rot;
            r_px      <= piece_x;
            r_py      <= piece_y;
            r_colour  <= colour;
            r_idx     <= 2'd0;
            r_collide <= 1'b0;
          end
        end
        ST_RD_ADDR: begin
          if (w_oob) begin
            r_collide <= w_collide_nxt;
            r_idx     <= r_idx + 2'd1;
          end else begin
            r_ram_addr <= w_addr;
            r_ram_wren <= 1'b0;
          end
        end
        ST_RD_SAMPLE: begin
          r_collide <= w_collide_nxt;
          r_idx     <= r_idx + 2'd1;
        end
        ST_WR: begin
          r_ram_addr <= w_addr;
          r_ram_data <= r_colour;
          r_ram_wren <= 1'b1;
        end
        ST_WR_END: begin
          r_ram_wren <= 1'b0;
          r_idx      <= r_idx + 2'd1;
          if (w_last) begin
            r_ram_addr <= 8'd0;
            r_ram_data <= 6'd0;
            r_clr_en   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_complete) r_clr_en <= 1'b0;
        end
        default: begin
          r_ram_wren <= 1'b0;
        end
      endcase
      // The RAM port is released whenever the operation finishes.
      if (w_state_nxt == ST_DONE) begin
        r_ram_addr <= 8'd0;
        r_ram_data <= 6'd0;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ram_wren   = r_ram_wren;
  assign clr_enable = r_clr_en;
  assign collide    = r_collide;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_piece_commit.sv
// tb_piece_commit: randomized and directed checks of piece_commit against a
// cell-list reference model, a behavioural board RAM and a row-clear responder.
module tb_piece_commit;
  localparam int CLR_DLY = 7;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       op;
  logic [2:0] shape;
  logic [1:0] rot;
  logic [4:0] piece_x;
  logic [5:0] piece_y;
  logic [5:0] colour;
  logic [5:0] ram_Q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       clr_enable;
  logic       clr_complete;
  logic       busy;
  logic       collide;
  logic       done;

  int n_total = 0;
  int n_bad   = 0;

  logic [5:0] mem [0:255] = '{default: 6'd0};
  logic [5:0] ref_board [0:255] = '{default: 6'd0};
  logic [7:0] wr_addr_q [$];
  logic [5:0] wr_data_q [$];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [5:0] pre_data;
  int         clr_cnt;

  int bdx [7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{1,0,1,2}, '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
  int bdy [7][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
  int m_cx [4];
  int m_cy [4];

  piece_commit dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .shape(shape), .rot(rot),
    .piece_x(piece_x), .piece_y(piece_y), .colour(colour), .ram_Q(ram_Q),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .clr_enable(clr_enable), .clr_complete(clr_complete), .busy(busy),
    .collide(collide), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM: one-cycle registered read of the registered address, write log.
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_data);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
    ram_Q <= mem[ram_addr];
  end

  // Row-clear responder: completes CLR_DLY cycles after enable rises.
  always @(posedge clk) begin
    if (!clr_enable) begin
      clr_cnt      <= 0;
      clr_complete <= 1'b0;
    end else if (clr_cnt == CLR_DLY - 1) begin
      clr_complete <= 1'b1;
    end else begin
      clr_cnt <= clr_cnt + 1;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic ref_piece(input int sh, input int rt, input int px, input int py);
    int s;
    int dx;
    int dy;
    int t;
    s = (sh == 7) ? 1 : sh;
    for (int i = 0; i < 4; i++) begin
      dx = bdx[s][i];
      dy = bdy[s][i];
      for (int r = 0; r < rt; r++) begin
        t  = dx;
        dx = 3 - dy;
        dy = t;
      end
      m_cx[i] = px + dx;
      m_cy[i] = py + dy;
    end
  endtask

  task automatic preload(input int a, input int v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 8'(a);
    pre_data = 6'(v);
    @(negedge clk);
    pre_we = 1'b0;
    ref_board[a] = 6'(v);
  endtask

  task automatic run_op(input int op_i, input int sh, input int rt, input int px,
                        input int py, input int col, input bit poke);
    int  exp_done;
    int  exp_col;
    int  ea [4];
    bit  do_wr;
    int  base;
    int  cyc;
    int  got_done;
    int  clr_cyc;
    ref_piece(sh, rt, px, py);
    exp_col  = 0;
    exp_done = 1;
    for (int i = 0; i < 4; i++) begin
      ea[i] = m_cy[i] * 10 + m_cx[i];
      if (m_cx[i] >= 10 || m_cy[i] >= 24) begin
        exp_col  = 1;
        exp_done += 1;
      end else begin
        if (ref_board[ea[i]] != 6'd0) exp_col = 1;
        exp_done += 3;
      end
    end
    do_wr = (op_i != 0) && (exp_col == 0);
    if (do_wr) exp_done = exp_done + 8 + CLR_DLY + 1;
    base = wr_addr_q.size();

    @(negedge clk);
    start   = 1'b1;
    op      = op_i[0];
    shape   = 3'(sh);
    rot     = 2'(rt);
    piece_x = 5'(px);
    piece_y = 6'(py);
    colour  = 6'(col);
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    got_done = 0;
    clr_cyc  = 0;
    chk_val("busy_run", busy, 1);
    while (got_done == 0 && cyc <= 200) begin
      if (clr_enable && clr_cyc == 0) begin
        clr_cyc = cyc;
        chk_val("clr_port_idle", {ram_addr, ram_data, ram_wren}, 0);
      end
      if (done) got_done = cyc;
      if (poke && cyc == 4) begin
        start = 1'b1; op = 1'b1; shape = 3'd0; piece_x = 5'd0; piece_y = 6'd0;
      end
      if (poke && cyc == 5) start = 1'b0;
      if (got_done == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (got_done == 0) begin
      chk_val("done_timeout", 0, 1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      return;
    end
    chk_val("done_cycle", got_done, exp_done);
    chk_val("collide", collide, exp_col);
    chk_val("clr_cycle", clr_cyc, do_wr ? 21 : 0);
    chk_val("n_writes", wr_addr_q.size() - base, do_wr ? 4 : 0);
    if (do_wr && wr_addr_q.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_val("wr_addr", wr_addr_q[base + i], ea[i]);
        chk_val("wr_data", wr_data_q[base + i], col);
        ref_board[ea[i]] = 6'(col);
      end
    end
    @(negedge clk);
    chk_val("after_done", {busy, done}, 0);
    chk_val("collide_held", collide, exp_col);
  endtask

  initial begin
    int base;
    int diffs;
    resetn = 1'b0; start = 1'b0; op = 1'b0; shape = 3'd0; rot = 2'd0;
    piece_x = 5'd0; piece_y = 6'd0; colour = 6'd0; pre_we = 1'b0;
    pre_addr = 8'd0; pre_data = 6'd0;
    repeat (3) @(negedge clk);
    chk_val("reset_outs", {ram_addr, ram_data, ram_wren, clr_enable, busy, collide, done}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk_val("idle_busy", busy, 0);

    run_op(0, 2, 0, 3, 0, 5, 1'b0);
    preload(14, 5);
    run_op(0, 1, 0, 3, 0, 7, 1'b0);
    run_op(0, 1, 0, 0, 22, 7, 1'b0);
    run_op(0, 1, 0, 0, 23, 7, 1'b0);
    run_op(1, 1, 0, 0, 23, 7, 1'b0);
    run_op(0, 0, 0, 8, 0, 7, 1'b0);
    run_op(1, 0, 0, 8, 0, 7, 1'b0);

    base = wr_addr_q.size();
    run_op(1, 0, 1, 0, 20, 3, 1'b0);
    chk_val("i_col_addr0", wr_addr_q[base], 202);
    chk_val("i_col_addr3", wr_addr_q[base + 3], 232);

    base = wr_addr_q.size();
    run_op(0, 2, 2, 4, 5, 1, 1'b1);
    repeat (30) @(negedge clk);
    chk_val("busy_start_ignored", wr_addr_q.size() - base, 0);

    // Abort a commit during the write of cell 2 (cells at 106,115,116,117).
    base = wr_addr_q.size();
    @(negedge clk);
    start = 1'b1; op = 1'b1; shape = 3'd2; rot = 2'd0;
    piece_x = 5'd5; piece_y = 6'd10; colour = 6'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_val("abort_outs", {ram_addr, ram_data, ram_wren, clr_enable, busy, collide, done}, 0);
    chk_val("abort_nwr", wr_addr_q.size() - base, 2);
    chk_val("abort_wr0", wr_addr_q[base], 106);
    chk_val("abort_wr1", wr_addr_q[base + 1], 115);
    ref_board[106] = 6'd9;
    ref_board[115] = 6'd9;
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    chk_val("abort_idle", {busy, clr_enable}, 0);
    chk_val("abort_no_retry", wr_addr_q.size() - base, 2);

    for (int k = 0; k < 15; k++) preload($urandom_range(0, 239), $urandom_range(1, 63));
    for (int k = 0; k < 40; k++) begin
      run_op($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 12), $urandom_range(0, 25), $urandom_range(1, 63), 1'b0);
    end

    diffs = 0;
    for (int a = 0; a < 240; a++) if (mem[a] !== ref_board[a]) diffs++;
    chk_val("board_contents", diffs, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
